// File: rtl/maze_pkg.sv
// Shared maze geometry, sequencer defaults and FSM state encoding
// for the maze generation sequencer.
package maze_pkg;

  localparam int MAZE_W     = 16;
  localparam int MAZE_H     = 16;
  localparam int MAZE_CELLS = 256;

  localparam int DEF_START_HOLD  = 4;
  localparam int DEF_MIN_OPEN    = 64;
  localparam int DEF_MAX_RETRY   = 7;
  localparam int DEF_WDOG_CYCLES = 4096;

  localparam logic [2:0] ENC_IDLE    = 3'd0;
  localparam logic [2:0] ENC_START   = 3'd1;
  localparam logic [2:0] ENC_RUN     = 3'd2;
  localparam logic [2:0] ENC_CAPTURE = 3'd3;
  localparam logic [2:0] ENC_COUNT   = 3'd4;
  localparam logic [2:0] ENC_CHECK   = 3'd5;
  localparam logic [2:0] ENC_READY   = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE    = ENC_IDLE,
    ST_START   = ENC_START,
    ST_RUN     = ENC_RUN,
    ST_CAPTURE = ENC_CAPTURE,
    ST_COUNT   = ENC_COUNT,
    ST_CHECK   = ENC_CHECK,
    ST_READY   = ENC_READY
  } seq_state_e;

endpackage

// File: rtl/maze_gen_sequencer_if.sv
// Requester-side bundle of the maze sequencer: request/ack handshake plus
// the validated maze and its status.
interface maze_gen_sequencer_if;
  import maze_pkg::*;

  logic                  gen_req;
  logic                  maze_ack;
  logic [MAZE_CELLS-1:0] maze_out;
  logic                  maze_valid;
  logic [8:0]            open_count;
  logic [2:0]            retry_count;
  logic                  busy;
  logic                  wdog_err;

  modport master (
    output gen_req, maze_ack,
    input  maze_out, maze_valid, open_count, retry_count, busy, wdog_err
  );

  modport slave (
    input  gen_req, maze_ack,
    output maze_out, maze_valid, open_count, retry_count, busy, wdog_err
  );

endinterface

// File: rtl/maze_gen_sequencer_row_popcount.sv
// Combinational popcount of one 16-cell maze row (0..16).
module maze_row_popcount
  import maze_pkg::*;
(
  input  logic [MAZE_W-1:0] row_i,
  output logic [4:0]        count_o
);

  // Ripple sum of the open cells in the row
  always_comb begin
    count_o = 5'd0;
    for (int i = 0; i < MAZE_W; i++) begin
      count_o = count_o + {4'd0, row_i[i]};
    end
  end

endmodule

// File: rtl/maze_gen_sequencer.sv
// Sequences the maze carver, scores the snapshot and hands a validated maze
// to the requester. Optional RUN watchdog: define MAZE_SEQ_WATCHDOG_EN.
module maze_gen_sequencer
  import maze_pkg::*;
#(
  parameter int START_HOLD = DEF_START_HOLD,
  parameter int MIN_OPEN   = DEF_MIN_OPEN,
  parameter int MAX_RETRY  = DEF_MAX_RETRY
) (
  input  logic                  clk,
  input  logic                  reset,
  maze_gen_sequencer_if.slave   req,
  input  logic                  carver_finish,
  input  logic [MAZE_CELLS-1:0] carver_maze,
  output logic                  carver_start
);

  localparam logic [12:0] HOLD_LAST = 13'(START_HOLD - 1);
`ifdef MAZE_SEQ_WATCHDOG_EN
  localparam logic [12:0] WDOG_LAST = 13'(DEF_WDOG_CYCLES - 1);
`endif

  seq_state_e            state_q, state_d;
  logic [12:0]           cnt_q, cnt_d;
  logic [8:0]            acc_q, acc_d;
  logic [2:0]            retry_q, retry_d;
  logic [MAZE_CELLS-1:0] maze_q, maze_d;
  logic [8:0]            open_q, open_d;
  logic                  wdog_q, wdog_d;
  logic                  start_q, valid_q, busy_q;
  logic [MAZE_W-1:0]     row_s;
  logic [4:0]            row_cnt_s;
  logic [8:0]            sum_s;

  // cnt_q doubles as START hold counter, RUN cycle counter and COUNT row index
  assign row_s = maze_q[{cnt_q[3:0], 4'd0} +: MAZE_W];
  assign sum_s = acc_q + {4'd0, row_cnt_s};

  maze_row_popcount u_row_popcount (
    .row_i   (row_s),
    .count_o (row_cnt_s)
  );

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    retry_d = retry_q;
    maze_d  = maze_q;
    open_d  = open_q;
    wdog_d  = wdog_q;
    case (state_q)
      ST_IDLE: begin
        if (req.gen_req) begin
          state_d = ST_START;
          retry_d = 3'd0;
          cnt_d   = 13'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if ((cnt_q >= HOLD_LAST) && !carver_finish) begin
          state_d = ST_RUN;
          cnt_d   = 13'd0;
        end else if (cnt_q < HOLD_LAST) begin
          cnt_d = cnt_q + 13'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_RUN: begin
        // A finish seen on the first RUN cycle is the stale flag from the last run
        if ((cnt_q != 13'd0) && carver_finish) begin
          state_d = ST_CAPTURE;
`ifdef MAZE_SEQ_WATCHDOG_EN
        end else if (cnt_q == WDOG_LAST) begin
          wdog_d = 1'b1;
          cnt_d  = 13'd0;
          if (retry_q == 3'(MAX_RETRY)) begin
            state_d = ST_READY;
          end else begin
            retry_d = retry_q + 3'd1;
            state_d = ST_START;
          end
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
`else
        end else begin
          cnt_d = 13'd1;
        end
`endif
      end
      ST_CAPTURE: begin
        maze_d  = carver_maze;
        cnt_d   = 13'd0;
        acc_d   = 9'd0;
        state_d = ST_COUNT;
      end
      ST_COUNT: begin
        acc_d = sum_s;
        if (cnt_q[3:0] == 4'd15) begin
          open_d  = sum_s;
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end
      ST_CHECK: begin
        if ((open_q >= 9'(MIN_OPEN)) || (retry_q == 3'(MAX_RETRY))) begin
          state_d = ST_READY;
        end else begin
          retry_d = retry_q + 3'd1;
          cnt_d   = 13'd0;
          state_d = ST_START;
        end
      end
      ST_READY: begin
        if (req.maze_ack && req.gen_req) begin
          retry_d = 3'd0;
          cnt_d   = 13'd0;
          state_d = ST_START;
        end else if (req.maze_ack) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_READY;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs (outputs follow the next state)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 13'd0;
      acc_q   <= 9'd0;
      retry_q <= 3'd0;
      maze_q  <= '0;
      open_q  <= 9'd0;
      wdog_q  <= 1'b0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      retry_q <= retry_d;
      maze_q  <= maze_d;
      open_q  <= open_d;
      wdog_q  <= wdog_d;
      start_q <= (state_d == ST_START);
      valid_q <= (state_d == ST_READY);
      busy_q  <= (state_d != ST_IDLE) && (state_d != ST_READY);
    end
  end

  assign carver_start    = start_q;
  assign req.maze_out    = maze_q;
  assign req.maze_valid  = valid_q;
  assign req.open_count  = open_q;
  assign req.retry_count = retry_q;
  assign req.busy        = busy_q;
  assign req.wdog_err    = wdog_q;

endmodule

// File: tb/tb_maze_gen_sequencer.sv
// Directed self-checking bench for maze_gen_sequencer with a behavioural carver.
module tb_maze_gen_sequencer;
  import maze_pkg::*;

  logic                  clk;
  logic                  reset;
  logic                  carver_finish;
  logic [MAZE_CELLS-1:0] carver_maze;
  logic                  carver_start;

  maze_gen_sequencer_if bus();

  maze_gen_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .req           (bus),
    .carver_finish (carver_finish),
    .carver_maze   (carver_maze),
    .carver_start  (carver_start)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // carver model controls and observations
  logic [MAZE_CELLS-1:0] maze_list[$];
  int  run_len = 10;
  bit  never_finish = 1'b0;
  int  start_cnt = 0;
  bit  running = 1'b0;
  int  run_cnt = 0;
  bit  prev_start = 1'b0;
  int  start_rises = 0;
  int  start_hi = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Carver: drops finish after seeing start for 2 cycles, raises it run_len cycles after start falls
  initial begin
    carver_finish = 1'b1;
    carver_maze   = '0;
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        carver_finish = 1'b1;
        running = 1'b0;
        start_cnt = 0;
        prev_start = 1'b0;
      end else begin
        if (carver_start && !prev_start) start_rises++;
        if (carver_start) start_hi++;
        prev_start = carver_start;
        if (carver_start) begin
          start_cnt++;
          if (start_cnt == 2) begin
            carver_finish = 1'b0;
            running = 1'b1;
            run_cnt = 0;
          end
        end else begin
          start_cnt = 0;
          if (running) begin
            run_cnt++;
            if (run_cnt >= run_len && !never_finish) begin
              if (maze_list.size() > 1) carver_maze = maze_list.pop_front();
              else carver_maze = maze_list[0];
              carver_finish = 1'b1;
              running = 1'b0;
            end
          end
        end
      end
    end
  end

  function automatic logic [MAZE_CELLS-1:0] first_n(int n);
    logic [MAZE_CELLS-1:0] m;
    m = '0;
    for (int i = 0; i < n; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [MAZE_CELLS-1:0] diag10();
    logic [MAZE_CELLS-1:0] m;
    m = '0;
    for (int i = 0; i < 10; i++) m[i*16 + i] = 1'b1;
    return m;
  endfunction

  function automatic logic [MAZE_CELLS-1:0] checker_maze();
    logic [MAZE_CELLS-1:0] m;
    for (int i = 0; i < MAZE_CELLS; i++) m[i] = ((i % 16) + (i / 16)) % 2 == 1;
    return m;
  endfunction

  task automatic pulse_req();
    @(negedge clk);
    bus.gen_req = 1'b1;
    @(negedge clk);
    bus.gen_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({carver_start, bus.maze_valid, bus.busy, bus.wdog_err} !== 4'b0000 ||
        bus.open_count !== 9'd0 || bus.retry_count !== 3'd0 || bus.maze_out !== '0) begin
      errors++;
      $display("FAIL reset_state: start=%b valid=%b busy=%b wdog=%b open=%0d retry=%0d, required all zero",
               carver_start, bus.maze_valid, bus.busy, bus.wdog_err, bus.open_count, bus.retry_count);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int t, t_fin, t_val;
    maze_list = {first_n(256)};
    run_len = 36;
    start_rises = 0;
    start_hi = 0;
    pulse_req();
    t = 0;
    while (carver_finish !== 1'b0 && t < 100) begin @(negedge clk); t++; end
    t = 0;
    while (carver_finish !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    t_fin = cyc;
    t = 0;
    while (bus.maze_valid !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    t_val = cyc;
    checks++;
    if (bus.maze_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_valid: maze_valid=%b, required 1", bus.maze_valid);
    end
    // finish is sampled on the edge after t_fin; valid follows 18 cycles later
    checks++;
    if (t_val - (t_fin + 1) !== 18) begin
      errors++;
      $display("FAIL basic_latency: %0d cycles after finish, required 18", t_val - (t_fin + 1));
    end
    checks++;
    if (start_hi !== 4 || start_rises !== 1) begin
      errors++;
      $display("FAIL basic_start_len: start high %0d cycles in %0d pulses, required 4 in 1", start_hi, start_rises);
    end
    checks++;
    if (bus.open_count !== 9'd256 || bus.retry_count !== 3'd0) begin
      errors++;
      $display("FAIL basic_open: open=%0d retry=%0d, required 256 and 0", bus.open_count, bus.retry_count);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.maze_valid !== 1'b1 || bus.maze_out !== first_n(256) || bus.open_count !== 9'd256) begin
      errors++;
      $display("FAIL basic_stable: valid=%b open=%0d, required 1 and 256 with all-ones maze", bus.maze_valid, bus.open_count);
    end
    @(negedge clk); bus.maze_ack = 1'b1;
    @(negedge clk); bus.maze_ack = 1'b0;
    checks++;
    if (bus.maze_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_ack: valid=%b busy=%b, required 0 0", bus.maze_valid, bus.busy);
    end
  endtask

  task automatic test_blanking();
    int t, t_fin, t_val;
    maze_list = {checker_maze()};
    run_len = 1;
    pulse_req();
    t = 0;
    while (carver_finish !== 1'b0 && t < 100) begin @(negedge clk); t++; end
    t = 0;
    while (carver_finish !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    t_fin = cyc;
    t = 0;
    while (bus.maze_valid !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    t_val = cyc;
    // finish arrives in the first RUN cycle, is blanked, then captured one cycle later
    checks++;
    if (bus.maze_valid !== 1'b1 || t_val - t_fin !== 20 || bus.open_count !== 9'd128) begin
      errors++;
      $display("FAIL blanking: valid=%b delay=%0d open=%0d, required 1 20 128", bus.maze_valid, t_val - t_fin, bus.open_count);
    end
    @(negedge clk); bus.maze_ack = 1'b1;
    @(negedge clk); bus.maze_ack = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int t;
    maze_list = {first_n(200)};
    run_len = 300;
    pulse_req();
    t = 0;
    while (carver_start !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    t = 0;
    while (carver_start !== 1'b0 && t < 50) begin @(negedge clk); t++; end
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (carver_start !== 1'b0 || bus.busy !== 1'b0 || bus.maze_valid !== 1'b0 || bus.maze_out !== '0 || bus.open_count !== 9'd0) begin
      errors++;
      $display("FAIL reset_mid_run: start=%b busy=%b valid=%b open=%0d, required 0 0 0 0",
               carver_start, bus.busy, bus.maze_valid, bus.open_count);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || carver_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b start=%b, required 0 0", bus.busy, carver_start);
    end
  endtask

  task automatic test_retry_limit();
    int t;
    maze_list = {diag10()};
    run_len = 5;
    start_rises = 0;
    pulse_req();
    t = 0;
    while (bus.maze_valid !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
    checks++;
    if (bus.maze_valid !== 1'b1 || bus.retry_count !== 3'd7 || bus.open_count !== 9'd10) begin
      errors++;
      $display("FAIL retry_limit: valid=%b retry=%0d open=%0d, required 1 7 10", bus.maze_valid, bus.retry_count, bus.open_count);
    end
    checks++;
    if (start_rises !== 8) begin
      errors++;
      $display("FAIL retry_starts: %0d start pulses, required 8", start_rises);
    end
    @(negedge clk); bus.maze_ack = 1'b1;
    @(negedge clk); bus.maze_ack = 1'b0;
  endtask

  task automatic test_threshold();
    int t;
    maze_list = {first_n(63), first_n(64)};
    run_len = 4;
    start_rises = 0;
    pulse_req();
    t = 0;
    while (bus.maze_valid !== 1'b1 && t < 500) begin @(negedge clk); t++; end
    checks++;
    if (bus.maze_valid !== 1'b1 || bus.retry_count !== 3'd1 || bus.open_count !== 9'd64 || start_rises !== 2) begin
      errors++;
      $display("FAIL threshold: valid=%b retry=%0d open=%0d starts=%0d, required 1 1 64 2",
               bus.maze_valid, bus.retry_count, bus.open_count, start_rises);
    end
  endtask

  task automatic test_back_to_back();
    int t;
    maze_list = {checker_maze()};
    run_len = 6;
    @(negedge clk);
    bus.maze_ack = 1'b1;
    bus.gen_req  = 1'b1;
    @(negedge clk);
    bus.maze_ack = 1'b0;
    bus.gen_req  = 1'b0;
    checks++;
    if (bus.maze_valid !== 1'b0 || carver_start !== 1'b1 || bus.busy !== 1'b1 || bus.retry_count !== 3'd0) begin
      errors++;
      $display("FAIL back_to_back: valid=%b start=%b busy=%b retry=%0d, required 0 1 1 0",
               bus.maze_valid, carver_start, bus.busy, bus.retry_count);
    end
    t = 0;
    while (bus.maze_valid !== 1'b1 && t < 300) begin @(negedge clk); t++; end
    checks++;
    if (bus.maze_valid !== 1'b1 || bus.open_count !== 9'd128 || bus.maze_out !== checker_maze()) begin
      errors++;
      $display("FAIL back_to_back_result: valid=%b open=%0d, required 1 128", bus.maze_valid, bus.open_count);
    end
    @(negedge clk); bus.maze_ack = 1'b1;
    @(negedge clk); bus.maze_ack = 1'b0;
  endtask

  task automatic test_ignore();
    int t;
    maze_list = {first_n(100)};
    run_len = 8;
    start_rises = 0;
    @(negedge clk); bus.maze_ack = 1'b1;
    @(negedge clk); bus.maze_ack = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.maze_valid !== 1'b0 || carver_start !== 1'b0) begin
      errors++;
      $display("FAIL ignore_idle_ack: busy=%b valid=%b start=%b, required 0 0 0", bus.busy, bus.maze_valid, carver_start);
    end
    pulse_req();
    t = 0;
    while (carver_start !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    t = 0;
    while (carver_start !== 1'b0 && t < 50) begin @(negedge clk); t++; end
    bus.maze_ack = 1'b1;
    @(negedge clk);
    bus.maze_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.maze_valid !== 1'b0 || carver_start !== 1'b0) begin
      errors++;
      $display("FAIL ignore_run_ack: busy=%b valid=%b start=%b, required 1 0 0", bus.busy, bus.maze_valid, carver_start);
    end
    t = 0;
    while (carver_finish !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    repeat (5) @(negedge clk);
    bus.gen_req = 1'b1;
    @(negedge clk);
    bus.gen_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || carver_start !== 1'b0) begin
      errors++;
      $display("FAIL ignore_count_req: busy=%b start=%b, required 1 0", bus.busy, carver_start);
    end
    t = 0;
    while (bus.maze_valid !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.maze_valid !== 1'b1 || start_rises !== 1 || bus.open_count !== 9'd100 || bus.retry_count !== 3'd0) begin
      errors++;
      $display("FAIL ignore_result: valid=%b starts=%0d open=%0d retry=%0d, required 1 1 100 0",
               bus.maze_valid, start_rises, bus.open_count, bus.retry_count);
    end
    @(negedge clk); bus.maze_ack = 1'b1;
    @(negedge clk); bus.maze_ack = 1'b0;
  endtask

  task automatic test_watchdog();
`ifdef MAZE_SEQ_WATCHDOG_EN
    int t;
    maze_list = {first_n(80)};
    run_len = 5;
    never_finish = 1'b1;
    start_rises = 0;
    pulse_req();
    t = 0;
    while (bus.wdog_err !== 1'b1 && t < 5000) begin @(negedge clk); t++; end
    checks++;
    if (bus.wdog_err !== 1'b1 || bus.retry_count !== 3'd1 || carver_start !== 1'b1 || start_rises !== 2) begin
      errors++;
      $display("FAIL watchdog: wdog=%b retry=%0d start=%b starts=%0d, required 1 1 1 2",
               bus.wdog_err, bus.retry_count, carver_start, start_rises);
    end
    checks++;
    if (t < 4096) begin
      errors++;
      $display("FAIL watchdog_early: fired after %0d cycles, required at least 4096", t);
    end
    never_finish = 1'b0;
    t = 0;
    while (bus.maze_valid !== 1'b1 && t < 300) begin @(negedge clk); t++; end
    checks++;
    if (bus.maze_valid !== 1'b1 || bus.open_count !== 9'd80 || bus.wdog_err !== 1'b1) begin
      errors++;
      $display("FAIL watchdog_recover: valid=%b open=%0d wdog=%b, required 1 80 1", bus.maze_valid, bus.open_count, bus.wdog_err);
    end
    @(negedge clk); bus.maze_ack = 1'b1;
    @(negedge clk); bus.maze_ack = 1'b0;
`else
    checks++;
    if (bus.wdog_err !== 1'b0) begin
      errors++;
      $display("FAIL wdog_tied: wdog_err=%b, required 0", bus.wdog_err);
    end
`endif
  endtask

  initial begin
    reset = 1'b1;
    bus.gen_req = 1'b0;
    bus.maze_ack = 1'b0;
    test_reset();
    test_basic();
    test_blanking();
    test_reset_mid_run();
    test_retry_limit();
    test_threshold();
    test_back_to_back();
    test_ignore();
    test_watchdog();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
